// File: rtl/mem_access_ctrl_pkg.sv
// Shared op codes, bus size codes and FSM state encoding for the memory-stage access controller.
// Purely declarative; no logic.
package mem_access_ctrl_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_CANCEL = 3'd4
  } mac_state_e;

  // Everything the bus side needs to know about the op in EX/MEM, decoded in one place.
  typedef struct packed {
    logic        is_mem;
    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_store_align.sv
// Combinational op/address decode: access size, misalignment, big-endian byte strobes and lane-replicated store data.
// Zero latency; no flow control.
module mem_store_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [7:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output mem_req_t    o_req
);

  always_comb begin
    o_req            = '0;
    o_req.wdata      = i_wdata;
    case (i_op)
      EXE_LB_OP, EXE_LBU_OP: begin
        o_req.is_mem  = 1'b1;
        o_req.is_load = 1'b1;
        o_req.size    = MEM_SIZE_BYTE;
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        o_req.is_mem     = 1'b1;
        o_req.is_load    = 1'b1;
        o_req.size       = MEM_SIZE_HALF;
        o_req.misaligned = i_addr_lo[0];
      end
      EXE_LW_OP: begin
        o_req.is_mem     = 1'b1;
        o_req.is_load    = 1'b1;
        o_req.size       = MEM_SIZE_WORD;
        o_req.misaligned = |i_addr_lo;
      end
      EXE_SB_OP: begin
        o_req.is_mem   = 1'b1;
        o_req.is_store = 1'b1;
        o_req.size     = MEM_SIZE_BYTE;
        // Offset 0 is the most significant lane.
        o_req.wstrb    = 4'b1000 >> i_addr_lo;
        o_req.wdata    = {4{i_wdata[7:0]}};
      end
      EXE_SH_OP: begin
        o_req.is_mem     = 1'b1;
        o_req.is_store   = 1'b1;
        o_req.size       = MEM_SIZE_HALF;
        o_req.misaligned = i_addr_lo[0];
        o_req.wstrb      = i_addr_lo[1] ? 4'b0011 : 4'b1100;
        o_req.wdata      = {2{i_wdata[15:0]}};
      end
      EXE_SW_OP: begin
        o_req.is_mem     = 1'b1;
        o_req.is_store   = 1'b1;
        o_req.size       = MEM_SIZE_WORD;
        o_req.misaligned = |i_addr_lo;
        o_req.wstrb      = 4'b1111;
      end
      default: o_req.wdata = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage bus controller: alignment exceptions, req/addr_ok/data_ok handshake, read-word hold for the extractor.
// Min 3 cycles start-to-DONE; stalls the pipeline until DONE, then holds in DONE while the pipeline is stalled externally.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [7:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_stall_ext,
  input  logic        flush,
  output logic        stall_o,
  output logic [31:0] load_rdata_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic [31:0] badvaddr_o,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  mem_req_t   w_req;
  mac_state_e r_state;
  mac_state_e w_state_nxt;
  logic       w_start;
  logic       w_latch;
  logic       w_capture;
  logic       r_cancel;
  logic       r_data_req;
  logic       r_data_wr;
  logic [1:0] r_data_size;
  logic [3:0] r_data_wstrb;
  logic [31:0] r_data_addr;
  logic [31:0] r_data_wdata;
  logic [31:0] r_load_rdata;

  mem_store_align u_align (
    .i_op      (mem_op),
    .i_addr_lo (mem_addr[1:0]),
    .i_wdata   (mem_wdata),
    .o_req     (w_req)
  );

  assign w_start = mem_valid & w_req.is_mem & ~w_req.misaligned & ~flush;

  assign adel_o     = ~rst & mem_valid & ~flush & w_req.misaligned & w_req.is_load;
  assign ades_o     = ~rst & mem_valid & ~flush & w_req.misaligned & w_req.is_store;
  assign badvaddr_o = (adel_o | ades_o) ? mem_addr : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_state_nxt = ST_REQ;
      // A flush seen at any point during REQ still lets addr_ok complete, then drains the data beat.
      ST_REQ:    if (data_addr_ok) w_state_nxt = (r_cancel || flush) ? ST_CANCEL : ST_WAIT;
      ST_WAIT: begin
        if (data_data_ok) w_state_nxt = flush ? ST_IDLE : ST_DONE;
        else if (flush)   w_state_nxt = ST_CANCEL;
      end
      ST_DONE:   if (flush || !mem_stall_ext) w_state_nxt = ST_IDLE;
      ST_CANCEL: if (data_data_ok) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_o   = 1'b0;
    w_latch   = 1'b0;
    w_capture = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          stall_o = w_start;
          w_latch = w_start;
        end
        ST_REQ, ST_CANCEL: stall_o = 1'b1;
        ST_WAIT: begin
          stall_o   = 1'b1;
          w_capture = data_data_ok & ~flush & ~r_data_wr;
        end
        default: stall_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_req   <= 1'b0;
      r_data_wr    <= 1'b0;
      r_data_size  <= 2'd0;
      r_data_wstrb <= 4'd0;
      r_data_addr  <= 32'd0;
      r_data_wdata <= 32'd0;
    end else if (w_latch) begin
      r_data_req   <= 1'b1;
      r_data_wr    <= w_req.is_store;
      r_data_size  <= w_req.size;
      r_data_wstrb <= w_req.wstrb;
      r_data_addr  <= mem_addr;
      r_data_wdata <= w_req.wdata;
    end else if (r_state == ST_REQ && data_addr_ok) begin
      r_data_req <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    r_cancel <= 1'b0;
    else if (r_state != ST_REQ) r_cancel <= 1'b0;
    else if (flush)             r_cancel <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)            r_load_rdata <= 32'd0;
    else if (w_capture) r_load_rdata <= data_rdata;
  end

  assign data_req     = r_data_req;
  assign data_wr      = r_data_wr;
  assign data_size    = r_data_size;
  assign data_wstrb   = r_data_wstrb;
  assign data_addr    = r_data_addr;
  assign data_wdata   = r_data_wdata;
  assign load_rdata_o = r_load_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized bench for mem_access_ctrl against a transaction-level reference model.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [7:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_stall_ext;
  logic        flush;
  logic        stall_o;
  logic [31:0] load_rdata_o;
  logic        adel_o;
  logic        ades_o;
  logic [31:0] badvaddr_o;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .mem_valid     (mem_valid),
    .mem_op        (mem_op),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_stall_ext (mem_stall_ext),
    .flush         (flush),
    .stall_o       (stall_o),
    .load_rdata_o  (load_rdata_o),
    .adel_o        (adel_o),
    .ades_o        (ades_o),
    .badvaddr_o    (badvaddr_o),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_wstrb    (data_wstrb),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access width in bytes, 0 for non-memory ops.
  function automatic int op_bytes(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
      EXE_LW_OP, EXE_SW_OP:             return 4;
      default:                          return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  // Big-endian lanes: an nb-byte mask anchored at the top lane, moved down by the byte offset.
  function automatic logic [31:0] exp_strb(input logic [7:0] op, input logic [31:0] addr);
    int nb;
    int mask;
    nb = op_bytes(op);
    if (!op_store(op)) return 32'd0;
    mask = ((1 << nb) - 1) << (4 - nb);
    return 32'((mask >> (addr % 4)) & 15);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [31:0] wd);
    case (op_bytes(op))
      1:       return {24'd0, wd[7:0]} * 32'h0101_0101;
      2:       return {16'd0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  task automatic clear_inputs();
    mem_valid     = 1'b0;
    mem_op        = 8'h00;
    mem_addr      = 32'd0;
    mem_wdata     = 32'd0;
    mem_stall_ext = 1'b0;
    flush         = 1'b0;
    data_addr_ok  = 1'b0;
    data_data_ok  = 1'b0;
    data_rdata    = 32'd0;
  endtask

  // One instruction through the stage with given bus delays and extra DONE stall cycles.
  task automatic run_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input int aok_dly, input int dok_dly, input logic [31:0] rd, input int ext);
    int nb;
    bit st;
    nb = op_bytes(op);
    st = op_store(op);
    mem_valid = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wd;
    flush = 1'b0; mem_stall_ext = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    if ((addr % nb) != 0) begin
      chk("exc_adel", {31'd0, adel_o}, {31'd0, !st});
      chk("exc_ades", {31'd0, ades_o}, {31'd0, st});
      chk("exc_badvaddr", badvaddr_o, addr);
      chk("exc_stall", {31'd0, stall_o}, 32'd0);
      tick();
      chk("exc_no_req", {31'd0, data_req}, 32'd0);
      mem_valid = 1'b0;
      return;
    end
    chk("start_stall", {31'd0, stall_o}, 32'd1);
    chk("start_no_exc", {30'd0, adel_o, ades_o}, 32'd0);
    tick();
    for (int i = 0; i <= aok_dly; i++) begin
      data_addr_ok = (i == aok_dly);
      #1;
      chk("req_held", {31'd0, data_req}, 32'd1);
      chk("req_stall", {31'd0, stall_o}, 32'd1);
      if (i == 0) begin
        chk("bus_addr", data_addr, addr);
        chk("bus_wr", {31'd0, data_wr}, {31'd0, st});
        chk("bus_size", {30'd0, data_size}, $clog2(nb));
        chk("bus_wstrb", {28'd0, data_wstrb}, exp_strb(op, addr));
        if (st) chk("bus_wdata", data_wdata, exp_wdata(op, wd));
      end
      tick();
    end
    data_addr_ok = 1'b0;
    for (int j = 0; j <= dok_dly; j++) begin
      data_data_ok = (j == dok_dly);
      data_rdata   = (j == dok_dly) ? rd : ~rd;
      #1;
      chk("wait_no_req", {31'd0, data_req}, 32'd0);
      chk("wait_stall", {31'd0, stall_o}, 32'd1);
      tick();
    end
    data_data_ok = 1'b0;
    if (!st) m_rdata = rd;
    for (int k = 0; k <= ext; k++) begin
      mem_stall_ext = (k < ext);
      #1;
      chk("done_stall", {31'd0, stall_o}, 32'd0);
      chk("done_no_req", {31'd0, data_req}, 32'd0);
      chk("done_rdata", load_rdata_o, m_rdata);
      tick();
    end
    mem_stall_ext = 1'b0;
    mem_valid     = 1'b0;
  endtask

  initial begin
    logic [7:0] ops [8];
    ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

    // Reset: everything quiet even with a misaligned op presented.
    clear_inputs();
    rst = 1'b1; mem_valid = 1'b1; mem_op = EXE_LH_OP; mem_addr = 32'h1001;
    tick(); tick();
    chk("rst_adel", {31'd0, adel_o}, 32'd0);
    chk("rst_badvaddr", badvaddr_o, 32'd0);
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_wr", {31'd0, data_wr}, 32'd0);
    chk("rst_size", {30'd0, data_size}, 32'd0);
    chk("rst_wstrb", {28'd0, data_wstrb}, 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    chk("rst_rdata", load_rdata_o, 32'd0);
    mem_op = EXE_LW_OP; mem_addr = 32'h1000;
    #1;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    m_rdata = 32'd0;
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();

    // Minimum-latency load, byte store with delayed addr_ok, misaligned ops.
    run_txn(EXE_LW_OP, 32'h1000, 32'd0, 0, 0, 32'hDEAD_BEEF, 0);
    run_txn(EXE_SB_OP, 32'h1003, 32'h0000_00A5, 3, 0, 32'h0, 0);
    run_txn(EXE_LH_OP, 32'h1001, 32'd0, 0, 0, 32'h0, 0);
    run_txn(EXE_SW_OP, 32'h1002, 32'h1234_5678, 0, 0, 32'h0, 0);
    run_txn(EXE_SH_OP, 32'h2002, 32'h0000_BEEF, 1, 2, 32'h0, 0);

    // Misaligned op under flush raises nothing.
    mem_valid = 1'b1; mem_op = EXE_LH_OP; mem_addr = 32'h1001; flush = 1'b1;
    #1;
    chk("flush_exc_adel", {31'd0, adel_o}, 32'd0);
    chk("flush_exc_badvaddr", badvaddr_o, 32'd0);
    tick();

    // Flush in the start cycle: no request.
    mem_op = EXE_LW_OP; mem_addr = 32'h1000;
    #1;
    chk("flush_start_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("flush_start_no_req", {31'd0, data_req}, 32'd0);
    flush = 1'b0; mem_valid = 1'b0;

    // Non-memory op does not stall.
    mem_valid = 1'b1; mem_op = 8'h21; mem_addr = 32'h1003;
    #1;
    chk("nonmem_stall", {31'd0, stall_o}, 32'd0);
    chk("nonmem_exc", {30'd0, adel_o, ades_o}, 32'd0);
    tick();
    chk("nonmem_no_req", {31'd0, data_req}, 32'd0);
    mem_valid = 1'b0;

    // Flush during REQ: request held to addr_ok, then data beat drained.
    mem_valid = 1'b1; mem_op = EXE_SH_OP; mem_addr = 32'h2000; mem_wdata = 32'h0000_1234;
    #1;
    chk("cancel_start_stall", {31'd0, stall_o}, 32'd1);
    tick();
    flush = 1'b1;
    #1;
    chk("cancel_req0", {31'd0, data_req}, 32'd1);
    tick();
    flush = 1'b0; mem_valid = 1'b0;
    #1;
    chk("cancel_req1", {31'd0, data_req}, 32'd1);
    chk("cancel_stall1", {31'd0, stall_o}, 32'd1);
    tick();
    data_addr_ok = 1'b1;
    #1;
    chk("cancel_req2", {31'd0, data_req}, 32'd1);
    tick();
    data_addr_ok = 1'b0;
    #1;
    chk("cancel_no_req", {31'd0, data_req}, 32'd0);
    chk("cancel_stall", {31'd0, stall_o}, 32'd1);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
    #1;
    chk("cancel_dok_stall", {31'd0, stall_o}, 32'd1);
    tick();
    data_data_ok = 1'b0;
    #1;
    chk("cancel_end_stall", {31'd0, stall_o}, 32'd0);
    chk("cancel_rdata", load_rdata_o, m_rdata);
    run_txn(EXE_LW_OP, 32'h3000, 32'd0, 0, 1, 32'h0BAD_F00D, 0);

    // Flush together with data_ok in WAIT: data discarded, back to IDLE.
    mem_valid = 1'b1; mem_op = EXE_LW_OP; mem_addr = 32'h4000;
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA; flush = 1'b1;
    #1;
    chk("wflush_stall", {31'd0, stall_o}, 32'd1);
    tick();
    data_data_ok = 1'b0; flush = 1'b0; mem_valid = 1'b0;
    #1;
    chk("wflush_rdata", load_rdata_o, m_rdata);
    chk("wflush_stall_after", {31'd0, stall_o}, 32'd0);

    // LBU held in DONE by an external stall, then a back-to-back start.
    run_txn(EXE_LBU_OP, 32'h1002, 32'd0, 0, 0, 32'h1122_3344, 2);

    // Reset in the middle of a transaction.
    mem_valid = 1'b1; mem_op = EXE_LW_OP; mem_addr = 32'h5000;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("mid_rst_req", {31'd0, data_req}, 32'd0);
    chk("mid_rst_rdata", load_rdata_o, 32'd0);
    m_rdata = 32'd0;
    rst = 1'b0; mem_valid = 1'b0;
    tick();

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      run_txn(ops[$urandom_range(7, 0)], $urandom, $urandom, int'($urandom_range(3, 0)),
              int'($urandom_range(3, 0)), $urandom, int'($urandom_range(2, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller sitting between the EX/MEM pipeline register and the SRAM-like data bus, directly upstream of the load data extractor. It:
- checks alignment and raises address-error exceptions;
- builds byte strobes and lane-replicated write data in big-endian lane order (address offset 0 maps to bits 31:24);
- runs the req/addr_ok/data_ok handshake and stalls the pipeline for the duration;
- holds the raw read word for the extractor until the pipeline advances.

## Interface
Parameters:
- none; datapath fixed at 32 bits.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, synchronous, active-high.
- mem_valid  in  1  EX/MEM holds a valid instruction.
- mem_op  in  8  ALU op code (`EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP`; anything else is a non-memory op).
- mem_addr  in  32  effective address.
- mem_wdata  in  32  store source register value.
- mem_stall_ext  in  1  another stage holds the pipeline this cycle.
- flush  in  1  exception/ERET flush of the memory stage.
- stall_o  out  1  memory stage not finished.
- load_rdata_o  out  32  raw captured read word, consumed by the extractor.
- adel_o, ades_o  out  1 each  load/store address error.
- badvaddr_o  out  32  faulting address.
- data_req, data_wr  out  1 each  bus request; write flag.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_wstrb  out  4  byte strobes; bit 3 is lane 31:24.
- data_addr, data_wdata  out  32 each  bus address; bus write data.
- data_addr_ok, data_data_ok  in  1 each  bus handshakes.
- data_rdata  in  32  bus read data.

## Operation
- start = mem_valid & mem op & !misaligned & !flush.
- Misaligned cases: LW/SW with addr[1:0]≠0; LH/LHU/SH with addr[0]≠0.
- Misaligned handling:
  - adel_o (load) or ades_o (store) is asserted combinationally while mem_valid & !flush.
  - badvaddr_o = mem_addr; otherwise 0.
  - No bus request is issued and stall_o = 0.
- Store lanes:
  - SB: wstrb = 1000 >> addr[1:0]; wdata = {4{mem_wdata[7:0]}}.
  - SH: wstrb 1100 at offset 00, 0011 at offset 10; wdata = {2{mem_wdata[15:0]}}.
  - SW: wstrb 1111; wdata = mem_wdata.
  - Loads: wstrb 0000.
- States and transitions:
  - IDLE: on start, latch addr/size/wr/wstrb/wdata into the bus output registers and go to REQ.
  - REQ: data_req = 1. data_req is held until data_addr_ok, then go to WAIT, or to CANCEL if a flush occurred while in REQ (sticky cancel flag).
  - WAIT: on data_data_ok, capture data_rdata into load_rdata_o (loads only) and go to DONE. A flush with no data_ok that cycle goes to CANCEL.
  - DONE: stay while mem_stall_ext = 1. Otherwise return to IDLE. Flush goes to IDLE.
  - CANCEL: wait for data_data_ok, discard the data, go to IDLE.
- stall_o:
  - 1 in IDLE & start, and in REQ, WAIT and CANCEL.
  - 0 in DONE, for non-memory ops, and while rst is asserted.
- data_ok is sampled only in WAIT and CANCEL. The bus guarantees data_ok arrives at least one cycle after addr_ok.
- A request is never withdrawn once raised, even under flush.
- load_rdata_o holds its value until the next load capture.

## Timing
- Reset values: state IDLE, cancel flag 0, data_req/data_wr 0, data_size 0, data_wstrb 0, data_addr/data_wdata 0, load_rdata_o 0. Exception outputs and stall_o are combinational and read 0 during reset.
- Minimum latency is 3 cycles. With addr_ok in the first REQ cycle and data_ok in the next cycle:
  - cycle 0 IDLE/start, stall 1;
  - cycle 1 REQ, addr_ok;
  - cycle 2 WAIT, data_ok;
  - cycle 3 DONE, stall 0 and load_rdata_o valid.
- A new start may occur in the cycle after DONE.
- A flush in the same cycle as start wins: no request is issued.
- A flush in the same cycle as data_ok in WAIT goes to IDLE and discards the data.
- Reset mid-transaction returns to IDLE immediately. The bus is reset alongside, so no cancel is tracked.

## Structure
- Op-code constants are taken from the shared defines header.
- Add `MEM_SIZE_BYTE/HALF/WORD` and the state encodings to the same header.
- One combinational sub-module, mem_store_align, covering the op + addr + wdata → size, wstrb, lane data, wr, misaligned decode.

## Test plan
- LW, addr 0x1000, addr_ok in cycle 1, data_ok in cycle 2 with rdata 0xDEADBEEF → stall 1,1,1,0; load_rdata_o = 0xDEADBEEF in DONE; data_size 2.
- SB, addr 0x1003, wdata 0x000000A5 → wstrb 0001, data_wdata 0xA5A5A5A5, data_wr 1. With addr_ok delayed 3 cycles, data_req is held for all 4 cycles.
- LH, addr 0x1001 → adel_o 1, badvaddr_o 0x1001, data_req stays 0, stall_o 0. SW, addr 0x1002 → ades_o 1.
- SH at 0x2000, flush asserted while in REQ before addr_ok → req held until addr_ok, then CANCEL until data_ok, then IDLE. load_rdata_o is unchanged.
- LBU completes with mem_stall_ext high for 2 cycles in DONE → FSM remains in DONE with no new request; it returns to IDLE in the cycle after mem_stall_ext drops.
